// File: rtl/prio_arbiter_pkg.sv
// Shared definitions for the priority / round-robin arbiter: policy encodings,
// FSM state type and index helpers used at elaboration and in the datapath.
package prio_arbiter_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Bits needed to index n items (at least 1).
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // (base + off + 1) mod n, for base, off < n; maps rotated positions back to requesters.
  function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off + 1;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-set-bit encoder: index of the top set bit plus a found flag.
module prio_enc_n
  import prio_arbiter_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2w(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// N-way arbiter with fixed-priority or round-robin policy and optional grant lock.
// One-cycle registered grant; asynchronous active-low reset.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  parameter  int LOCK = 1,
  localparam int W    = clog2w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  arb_state_e   state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         valid_q, valid_d;

  logic [N-1:0] arb_req;
  logic [N-1:0] rot_req;
  logic [N-1:0] enc_in;
  logic [W-1:0] enc_idx;
  logic [W-1:0] win_idx;
  logic         found;
  logic         hold;

  // On a locked release the outgoing winner never competes in the same cycle.
  assign arb_req = (LOCK != 0 && state_q == ST_GRANT) ? (req & ~gnt_q) : req;

  // Rotate so requester ptr lands on the top bit; the encoder's highest-first
  // search then walks ptr, ptr-1, ... with wrap.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot_req[gi] = arb_req[W'(wrap_idx(gi, 32'(ptr_q), N))];
  end

  assign enc_in = (MODE == MODE_RR) ? rot_req : arb_req;

  prio_enc_n #(.N(N)) u_enc (
    .vec   (enc_in),
    .idx   (enc_idx),
    .found (found)
  );

  assign win_idx = (MODE == MODE_RR) ? W'(wrap_idx(32'(enc_idx), 32'(ptr_q), N)) : enc_idx;
  assign hold    = (LOCK != 0) && (state_q == ST_GRANT) && req[idx_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (!hold) begin
      if (en && found) begin
        state_d = ST_GRANT;
        gnt_d   = N'(1) << win_idx;
        idx_d   = win_idx;
        valid_d = 1'b1;
        if (MODE == MODE_RR) begin
          ptr_d = (win_idx == '0) ? W'(N - 1) : win_idx - W'(1);
        end
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= W'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Three arbiter configurations driven side by side and checked every cycle
// against a requester-level model, plus hand-computed literal expectations.
module tb_prio_arbiter;

  typedef struct {
    int held;
    int ptr;
  } mst_t;

  localparam int CFG_N[3]    = '{8, 4, 5};
  localparam int CFG_MODE[3] = '{0, 1, 1};
  localparam int CFG_LOCK[3] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rq8;
  logic [3:0] rq4;
  logic [4:0] rq5;
  logic [2:0] en_v;
  logic [7:0] g8;
  logic [3:0] g4;
  logic [4:0] g5;
  logic [2:0] i8;
  logic [1:0] i4;
  logic [2:0] i5;
  logic       v8, v4, v5;

  logic [31:0] d_gnt[3];
  logic [31:0] d_idx[3];
  logic        d_val[3];
  mst_t        m_st[3];

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  always #5 clk = ~clk;

  prio_arbiter #(.N(8), .MODE(0), .LOCK(1)) u_a8 (
    .clk(clk), .rst_n(rst_n), .req(rq8), .en(en_v[0]),
    .gnt(g8), .gnt_idx(i8), .gnt_valid(v8));
  prio_arbiter #(.N(4), .MODE(1), .LOCK(0)) u_a4 (
    .clk(clk), .rst_n(rst_n), .req(rq4), .en(en_v[1]),
    .gnt(g4), .gnt_idx(i4), .gnt_valid(v4));
  prio_arbiter #(.N(5), .MODE(1), .LOCK(1)) u_a5 (
    .clk(clk), .rst_n(rst_n), .req(rq5), .en(en_v[2]),
    .gnt(g5), .gnt_idx(i5), .gnt_valid(v5));

  assign d_gnt[0] = {24'b0, g8};
  assign d_gnt[1] = {28'b0, g4};
  assign d_gnt[2] = {27'b0, g5};
  assign d_idx[0] = {29'b0, i8};
  assign d_idx[1] = {30'b0, i4};
  assign d_idx[2] = {29'b0, i5};
  assign d_val[0] = v8;
  assign d_val[1] = v4;
  assign d_val[2] = v5;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // First requester with req set, walking the policy's search order.
  function automatic int pick(input int n, input int mode, input int ptr, input logic [31:0] r);
    for (int s = 0; s < n; s++) begin
      int i;
      i = (mode == 0) ? n - 1 - s : (ptr - s + n) % n;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic mst_t mstep(input int k, input logic [31:0] r, input logic e, input mst_t cur);
    mst_t        nx;
    logic [31:0] avail;
    nx    = cur;
    avail = r;
    if (CFG_LOCK[k] != 0 && cur.held >= 0 && r[cur.held]) return cur;
    if (CFG_LOCK[k] != 0 && cur.held >= 0) avail[cur.held] = 1'b0;
    nx.held = e ? pick(CFG_N[k], CFG_MODE[k], cur.ptr, avail) : -1;
    if (nx.held >= 0 && CFG_MODE[k] == 1) nx.ptr = (nx.held == 0) ? CFG_N[k] - 1 : nx.held - 1;
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) m_st[k] <= '{held: -1, ptr: CFG_N[k] - 1};
    end else begin
      m_st[0] <= mstep(0, {24'b0, rq8}, en_v[0], m_st[0]);
      m_st[1] <= mstep(1, {28'b0, rq4}, en_v[1], m_st[1]);
      m_st[2] <= mstep(2, {27'b0, rq5}, en_v[2], m_st[2]);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int eg, ei, ev;
      eg = (m_st[k].held >= 0) ? (1 << m_st[k].held) : 0;
      ei = (m_st[k].held >= 0) ? m_st[k].held : 0;
      ev = (m_st[k].held >= 0) ? 1 : 0;
      chk($sformatf("n%0d_gnt", CFG_N[k]), int'(d_gnt[k]), eg);
      chk($sformatf("n%0d_idx", CFG_N[k]), int'(d_idx[k]), ei);
      chk($sformatf("n%0d_valid", CFG_N[k]), int'(d_val[k]), ev);
    end
  end

  // Drive one cycle's inputs at a falling edge; returns at the next falling edge.
  task automatic step(input logic [7:0] r8, input logic e8, input logic [3:0] r4,
                      input logic e4, input logic [4:0] r5, input logic e5);
    rq8  = r8;
    rq4  = r4;
    rq5  = r5;
    en_v = {e5, e4, e8};
    @(negedge clk);
    n_txn++;
    $display("txn %0d: req8=%b en8=%b req4=%b en4=%b req5=%b en5=%b -> idx8=%0d/%0b idx4=%0d/%0b idx5=%0d/%0b",
             n_txn, r8, e8, r4, e4, r5, e5, i8, v8, i4, v4, i5, v5);
  endtask

  int exp_rr[5] = '{3, 2, 1, 0, 3};

  initial begin
    rst_n = 1'b0;
    rq8 = '0; rq4 = '0; rq5 = '0; en_v = '0;
    repeat (3) @(negedge clk);
    chk("rst_v8", int'(v8), 0);
    chk("rst_g4", int'(g4), 0);
    chk("rst_i5", int'(i5), 0);
    rst_n = 1'b1;

    // Fixed priority with lock: highest index wins, then held, then handed over.
    step(8'b0010_0100, 1, 4'h0, 0, 5'h0, 0);
    chk("fix_gnt", int'(g8), 32);
    chk("fix_idx", int'(i8), 5);
    chk("fix_valid", int'(v8), 1);
    step(8'b1010_0100, 1, 4'h0, 0, 5'h0, 0);
    chk("fix_hold_hi", int'(i8), 5);
    step(8'b1010_0100, 0, 4'h0, 0, 5'h0, 0);
    chk("fix_hold_en0", int'(i8), 5);
    step(8'b0000_0100, 1, 4'h0, 0, 5'h0, 0);
    chk("fix_b2b_gnt", int'(g8), 4);
    chk("fix_b2b_idx", int'(i8), 2);
    step(8'b0000_0000, 1, 4'h0, 0, 5'h0, 0);
    chk("fix_idle", int'(v8), 0);

    // Enable gates grants from idle.
    for (int c = 0; c < 3; c++) begin
      step(8'hFF, 0, 4'h0, 0, 5'h0, 0);
      chk("en0_idle", int'(v8), 0);
    end
    step(8'hFF, 1, 4'h0, 0, 5'h0, 0);
    chk("en1_idx", int'(i8), 7);

    // Round robin without lock rotates every cycle.
    for (int c = 0; c < 5; c++) begin
      step(8'hFF, 1, 4'hF, 1, 5'h0, 0);
      chk($sformatf("rr4_seq%0d", c), int'(i4), exp_rr[c]);
    end
    step(8'hFF, 1, 4'b0101, 1, 5'h0, 0);
    step(8'hFF, 1, 4'b0101, 0, 5'h0, 0);
    chk("rr4_en0", int'(v4), 0);

    // Round robin with lock on a non-power-of-two width.
    step(8'hFF, 1, 4'h0, 0, 5'b00001, 1);
    chk("rr5_first", int'(i5), 0);
    step(8'hFF, 1, 4'h0, 0, 5'b10001, 1);
    chk("rr5_hold", int'(i5), 0);
    step(8'hFF, 1, 4'h0, 0, 5'b10000, 1);
    chk("rr5_wrap", int'(i5), 4);
    step(8'hFF, 1, 4'h0, 0, 5'b11111, 1);
    step(8'hFF, 1, 4'h0, 0, 5'b01111, 1);
    chk("rr5_next", int'(i5), 3);
    step(8'hFF, 1, 4'h0, 0, 5'b00111, 0);
    step(8'hFF, 1, 4'h0, 0, 5'b10101, 1);
    step(8'hFF, 1, 4'h0, 0, 5'b10001, 1);
    step(8'hFF, 1, 4'h0, 0, 5'b10000, 1);
    chk("rr5_wrap2", int'(i5), 4);

    // Asynchronous reset between edges while grants are held.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_g8", int'(g8), 0);
    chk("arst_v8", int'(v8), 0);
    chk("arst_i8", int'(i8), 0);
    chk("arst_v5", int'(v5), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h00, 0, 4'hF, 1, 5'b00011, 1);
    chk("arst_ptr4", int'(i4), 3);
    step(8'h00, 0, 4'hF, 1, 5'b00011, 1);
    chk("arst_ptr4b", int'(i4), 2);
    step(8'h00, 0, 4'h0, 0, 5'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
